ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. It consumes the ForwardA/ForwardB selects from the forwarding unit and picks each ALU operand from the ID/EX register file data, the EX/MEM ALU result or the MEM/WB write-back data. It computes the ALU result and registers it with control bits into the EX/MEM pipeline register. It also contains a 32-cycle iterative signed multiplier with HI/LO registers, and stalls upstream stages through EX_Busy while multiplying.

---
 rtl/ex_stage.sv | 219 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//
// Selects the forwarded ALU operands, computes the ALU result and registers
// it with the control bits into the EX/MEM pipeline register. It also holds
// an iterative signed shift-add multiplier with HI/LO registers, and asserts
// EX_Busy so the hazard unit stalls upstream while a multiply runs.
//
// Ports
//   clk, reset             rising-edge clock, async active-high reset
//   IDEX_*                 ID/EX register contents (operands, imm, shamt, rd,
//                          ALU op, ALUSrc and the control bits)
//   ForwardA/B             operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   MEMWB_WriteData        write-back value (forwarding source 01)
//   EXMEM_*                registered EX/MEM outputs
//   EX_Busy                combinational stall request
//
// Multiplier states
//   state | meaning
//   IDLE  | no multiply; a MULT in ID/EX latches operands here
//   MUL   | one shift-add step per cycle, WIDTH steps
//   DONE  | HI/LO valid; the MULT drains into EX/MEM without RegWrite

module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] IDEX_ReadData1,
    input  logic [WIDTH-1:0] IDEX_ReadData2,
    input  logic [WIDTH-1:0] IDEX_Imm,
    input  logic [4:0]       IDEX_Shamt,
    input  logic [4:0]       IDEX_Rd,
    input  logic [3:0]       IDEX_ALUOp,
    input  logic             IDEX_ALUSrc,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_MemWrite,
    input  logic             IDEX_MemtoReg,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] MEMWB_WriteData,
    output logic [WIDTH-1:0] EXMEM_ALUResult,
    output logic [WIDTH-1:0] EXMEM_WriteData,
    output logic [4:0]       EXMEM_Rd,
    output logic             EXMEM_RegWrite,
    output logic             EXMEM_MemRead,
    output logic             EXMEM_MemWrite,
    output logic             EXMEM_MemtoReg,
    output logic             EX_Busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_MFHI = 4'b1001;
    localparam logic [3:0] OP_MFLO = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   fwd_a, fwd_b, op_b;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] mcand, acc, acc_step, prod_final;
    logic [WIDTH-1:0]   mplier;
    logic               mul_neg;
    logic               mul_start;

    // Forwarding muxes; 2'b11 falls back to the register file value.
    always_comb begin
        case (ForwardA)
            2'b10:   fwd_a = EXMEM_ALUResult;
            2'b01:   fwd_a = MEMWB_WriteData;
            default: fwd_a = IDEX_ReadData1;
        endcase
        case (ForwardB)
            2'b10:   fwd_b = EXMEM_ALUResult;
            2'b01:   fwd_b = MEMWB_WriteData;
            default: fwd_b = IDEX_ReadData2;
        endcase
    end

    assign op_b = IDEX_ALUSrc ? IDEX_Imm : fwd_b;

    always_comb begin
        alu_result = '0;
        case (IDEX_ALUOp)
            OP_AND:  alu_result = fwd_a & op_b;
            OP_OR:   alu_result = fwd_a | op_b;
            OP_ADD:  alu_result = fwd_a + op_b;
            OP_XOR:  alu_result = fwd_a ^ op_b;
            OP_SLL:  alu_result = op_b << IDEX_Shamt;
            OP_SRL:  alu_result = op_b >> IDEX_Shamt;
            OP_SUB:  alu_result = fwd_a - op_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_NOR:  alu_result = ~(fwd_a | op_b);
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    assign mul_start = (IDEX_ALUOp == OP_MULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        EX_Busy   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mul_start) begin
                    state_nxt = ST_MUL;
                    EX_Busy   = 1'b1;
                end
            end
            ST_MUL: begin
                EX_Busy = 1'b1;
                if (count == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    assign a_mag = fwd_a[WIDTH-1] ? -fwd_a : fwd_a;
    assign b_mag = op_b[WIDTH-1]  ? -op_b  : op_b;

    assign acc_step   = mplier[0] ? (acc + mcand) : acc;
    assign prod_final = mul_neg ? -acc_step : acc_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_neg <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        count   <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        acc     <= '0;
                        mul_neg <= fwd_a[WIDTH-1] ^ op_b[WIDTH-1];
                    end
                end
                ST_MUL: begin
                    acc    <= acc_step;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        hi <= prod_final[2*WIDTH-1:WIDTH];
                        lo <= prod_final[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM loads every cycle: bubbles while busy, and the drained MULT
    // never writes the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EXMEM_ALUResult <= '0;
            EXMEM_WriteData <= '0;
            EXMEM_Rd        <= '0;
            EXMEM_RegWrite  <= 1'b0;
            EXMEM_MemRead   <= 1'b0;
            EXMEM_MemWrite  <= 1'b0;
            EXMEM_MemtoReg  <= 1'b0;
        end else if (EX_Busy) begin
            EXMEM_ALUResult <= '0;
            EXMEM_WriteData <= '0;
            EXMEM_Rd        <= '0;
            EXMEM_RegWrite  <= 1'b0;
            EXMEM_MemRead   <= 1'b0;
            EXMEM_MemWrite  <= 1'b0;
            EXMEM_MemtoReg  <= 1'b0;
        end else begin
            EXMEM_ALUResult <= alu_result;
            EXMEM_WriteData <= fwd_b;
            EXMEM_Rd        <= IDEX_Rd;
            EXMEM_RegWrite  <= IDEX_RegWrite & (state != ST_DONE);
            EXMEM_MemRead   <= IDEX_MemRead;
            EXMEM_MemWrite  <= IDEX_MemWrite;
            EXMEM_MemtoReg  <= IDEX_MemtoReg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized, scoreboard-checked bench for ex_stage.
// Stimulus pushes the expected EX/MEM contents for each clock edge; a
// monitor pops one entry per edge and compares.

module tb_ex_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
    logic [4:0]    IDEX_Shamt, IDEX_Rd;
    logic [3:0]    IDEX_ALUOp;
    logic          IDEX_ALUSrc, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg;
    logic [1:0]    ForwardA, ForwardB;
    logic [W-1:0]  MEMWB_WriteData;
    logic [W-1:0]  EXMEM_ALUResult, EXMEM_WriteData;
    logic [4:0]    EXMEM_Rd;
    logic          EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg;
    logic          EX_Busy;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .IDEX_ReadData1  (IDEX_ReadData1),
        .IDEX_ReadData2  (IDEX_ReadData2),
        .IDEX_Imm        (IDEX_Imm),
        .IDEX_Shamt      (IDEX_Shamt),
        .IDEX_Rd         (IDEX_Rd),
        .IDEX_ALUOp      (IDEX_ALUOp),
        .IDEX_ALUSrc     (IDEX_ALUSrc),
        .IDEX_RegWrite   (IDEX_RegWrite),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_MemWrite   (IDEX_MemWrite),
        .IDEX_MemtoReg   (IDEX_MemtoReg),
        .ForwardA        (ForwardA),
        .ForwardB        (ForwardB),
        .MEMWB_WriteData (MEMWB_WriteData),
        .EXMEM_ALUResult (EXMEM_ALUResult),
        .EXMEM_WriteData (EXMEM_WriteData),
        .EXMEM_Rd        (EXMEM_Rd),
        .EXMEM_RegWrite  (EXMEM_RegWrite),
        .EXMEM_MemRead   (EXMEM_MemRead),
        .EXMEM_MemWrite  (EXMEM_MemWrite),
        .EXMEM_MemtoReg  (EXMEM_MemtoReg),
        .EX_Busy         (EX_Busy)
    );

    typedef struct {
        logic [31:0] rd1, rd2, imm, memwb;
        logic [4:0]  shamt, rd;
        logic [3:0]  op;
        logic        src, rw, mr, mw, m2r;
        logic [1:0]  fa, fb;
    } op_t;

    typedef struct {
        logic [31:0] res, wd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        bit          chk_data;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_exmem = 0;
    bit          m_known = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] memwb);
        if (sel == 2'b10) return m_exmem;
        if (sel == 2'b01) return memwb;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return b << sh;
            4'd5:  return b >> sh;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            4'd9:  return m_hi;
            4'd10: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic op_t nop();
        op_t o;
        o.rd1 = 0; o.rd2 = 0; o.imm = 0; o.memwb = 0; o.shamt = 0; o.rd = 0;
        o.op = 0; o.src = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.m2r = 0; o.fa = 0; o.fb = 0;
        return o;
    endfunction

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [4:0] rd, input logic [1:0] fa);
        op_t o = nop();
        o.op = op; o.rd1 = rd1; o.rd2 = rd2; o.rd = rd; o.fa = fa; o.rw = 1'b1;
        return o;
    endfunction

    task automatic drive(input op_t o);
        IDEX_ReadData1 = o.rd1; IDEX_ReadData2 = o.rd2; IDEX_Imm = o.imm;
        IDEX_Shamt = o.shamt; IDEX_Rd = o.rd; IDEX_ALUOp = o.op; IDEX_ALUSrc = o.src;
        IDEX_RegWrite = o.rw; IDEX_MemRead = o.mr; IDEX_MemWrite = o.mw; IDEX_MemtoReg = o.m2r;
        ForwardA = o.fa; ForwardB = o.fb; MEMWB_WriteData = o.memwb;
    endtask

    task automatic issue(input op_t o);
        logic [31:0] a, bf, b;
        exp_t e;
        @(negedge clk);
        drive(o);
        a  = fwd_ref(o.fa, o.rd1, o.memwb);
        bf = fwd_ref(o.fb, o.rd2, o.memwb);
        b  = o.src ? o.imm : bf;
        e.res = alu_ref(o.op, a, b, o.shamt);
        e.wd = bf; e.rd = o.rd; e.ctrl = {o.rw, o.mr, o.mw, o.m2r}; e.chk_data = 1'b1;
        q.push_back(e);
        m_exmem = e.res;
        m_known = 1'b1;
        #1 check("busy_nonmult", {31'b0, EX_Busy}, 32'd0);
    endtask

    // A MULT occupies EX for W+2 cycles: W+1 busy cycles of bubbles, then
    // one cycle where it drains without RegWrite. abort_at >= 0 asserts
    // reset in that cycle instead.
    task automatic issue_mult(input op_t o, input int abort_at, input bit toggle);
        logic [31:0]        a, b;
        logic signed [63:0] p;
        exp_t               e;
        a = fwd_ref(o.fa, o.rd1, o.memwb);
        b = o.src ? o.imm : fwd_ref(o.fb, o.rd2, o.memwb);
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        for (int c = 0; c <= W + 1; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                reset = 1'b1;
                IDEX_ALUOp = 4'b0000;
                q.delete();
                m_hi = 0; m_lo = 0; m_exmem = 0; m_known = 1'b1;
                #1;
                check("busy_after_abort", {31'b0, EX_Busy}, 32'd0);
                check("exmem_res_after_abort", EXMEM_ALUResult, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            drive(o);
            if (toggle && c > 0) begin
                ForwardA = 2'($urandom_range(0, 3));
                MEMWB_WriteData = $urandom;
            end
            if (c <= W) begin
                e.res = 0; e.wd = 0; e.rd = 0; e.ctrl = 0; e.chk_data = 1'b1;
                m_exmem = 0;
            end else begin
                e.res = 0; e.wd = 0; e.rd = o.rd; e.ctrl = {1'b0, o.mr, o.mw, o.m2r};
                e.chk_data = 1'b0;
                m_known = 1'b0;
            end
            q.push_back(e);
            #1 check("busy_mult", {31'b0, EX_Busy}, (c <= W) ? 32'd1 : 32'd0);
        end
        m_hi = p[63:32];
        m_lo = p[31:0];
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_data) begin
                    check("exmem_result", EXMEM_ALUResult, e.res);
                    check("exmem_writedata", EXMEM_WriteData, e.wd);
                end
                check("exmem_rd", {27'b0, EXMEM_Rd}, {27'b0, e.rd});
                check("exmem_ctrl",
                      {28'b0, EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg},
                      {28'b0, e.ctrl});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 20));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : stimulus
        op_t o;
        logic [3:0] ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd12, 4'd9, 4'd10, 4'd11, 4'd15, 4'd8};
        reset = 1'b1;
        drive(nop());
        repeat (2) @(negedge clk);
        #1;
        check("reset_result", EXMEM_ALUResult, 0);
        check("reset_writedata", EXMEM_WriteData, 0);
        check("reset_ctrl", {27'b0, EXMEM_Rd, EXMEM_RegWrite, EXMEM_MemRead,
                             EXMEM_MemWrite, EXMEM_MemtoReg}, 0);
        check("reset_busy", {31'b0, EX_Busy}, 0);
        @(negedge clk);
        reset = 1'b0;

        issue(mk(4'd9, 0, 0, 5'd3, 2'b00));            // MFHI after reset -> 0
        issue(mk(4'd2, 5, 7, 5'd1, 2'b00));            // ADD -> 12
        issue(mk(4'd2, 3, 4, 5'd1, 2'b00));            // r1 = 7
        issue(mk(4'd6, 0, 2, 5'd2, 2'b10));            // r1 - 2 -> 5
        o = mk(4'd6, 0, 2, 5'd2, 2'b01); o.memwb = 9;
        issue(o);                                      // 9 - 2 -> 7

        issue_mult(mk(4'd8, 32'hFFFF_FFFD, 7, 5'd4, 2'b00), -1, 1'b0);
        issue(mk(4'd9, 0, 0, 5'd5, 2'b00));            // HI = FFFFFFFF
        issue(mk(4'd10, 0, 0, 5'd6, 2'b00));           // LO = FFFFFFEB

        issue_mult(mk(4'd8, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4, 2'b00), -1, 1'b1);
        issue(mk(4'd9, 0, 0, 5'd5, 2'b00));            // 3FFFFFFF
        issue(mk(4'd10, 0, 0, 5'd6, 2'b00));           // 00000001

        issue_mult(mk(4'd8, 5, 9, 5'd4, 2'b00), 10, 1'b0);
        issue(mk(4'd9, 0, 0, 5'd5, 2'b00));            // 0 after abort
        issue(mk(4'd10, 0, 0, 5'd6, 2'b00));
        issue_mult(mk(4'd8, 2, 2, 5'd4, 2'b00), -1, 1'b0);
        issue(mk(4'd10, 0, 0, 5'd6, 2'b00));           // 4

        o = mk(4'd2, 10, 99, 5'd7, 2'b00); o.src = 1; o.imm = 32'hFFFF_FFFF;
        issue(o);                                      // ADDI 10 + -1, store data 99
        o = mk(4'd4, 0, 32'h8000_0001, 5'd8, 2'b00); o.shamt = 31;
        issue(o);
        o = mk(4'd5, 0, 32'h8000_0000, 5'd8, 2'b00); o.shamt = 31;
        issue(o);
        issue(mk(4'd7, 32'hFFFF_FFFF, 1, 5'd9, 2'b00));
        issue(mk(4'd12, 32'hF0F0_0000, 32'h0000_0F0F, 5'd9, 2'b00));
        issue(mk(4'd15, 1, 2, 5'd9, 2'b11));

        for (int i = 0; i < 150; i++) begin
            o = nop();
            o.op = ops[$urandom_range(0, 13)];
            o.rd1 = rnd32(); o.rd2 = rnd32(); o.imm = rnd32(); o.memwb = rnd32();
            o.shamt = 5'($urandom_range(0, 31)); o.rd = 5'($urandom_range(0, 31));
            o.src = 1'($urandom_range(0, 1)); o.rw = 1'($urandom_range(0, 1));
            o.mr = 1'($urandom_range(0, 1)); o.mw = 1'($urandom_range(0, 1));
            o.m2r = 1'($urandom_range(0, 1));
            o.fa = 2'($urandom_range(0, 3)); o.fb = 2'($urandom_range(0, 3));
            if (!m_known && o.fa == 2'b10) o.fa = 2'b00;
            if (!m_known && o.fb == 2'b10) o.fb = 2'b00;
            if (o.op == 4'd8) issue_mult(o, -1, 1'($urandom_range(0, 1)));
            else              issue(o);
        end

        @(negedge clk);
        drive(nop());
        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
